// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Single req/ack external memory bus between arbiter and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        bus_timeout_o;

  modport master (
    output bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, bus_timeout_o,
    input  bus_data_i, bus_ack_i
  );

  modport slave (
    input  bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, bus_timeout_o,
    output bus_data_i, bus_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory bus between IF and MEM (MEM first), with
//               per-requester stall requests and an optional wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  wire               clk,
  input  wire               reset_n,
  input  wire               if_ce_i,
  input  wire        [31:0] if_addr_i,
  output logic       [31:0] if_inst_o,
  output logic              stallreq_if_o,
  input  wire               mem_ce_i,
  input  wire               mem_we_i,
  input  wire        [3:0]  mem_sel_i,
  input  wire        [31:0] mem_addr_i,
  input  wire        [31:0] mem_data_i,
  output logic       [31:0] mem_data_o,
  output logic              stallreq_mem_o,
  input  wire               flush_i,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BUS_MEM  = 3'd1,
    S_BUS_IF   = 3'd2,
    S_DONE_MEM = 3'd3,
    S_DONE_IF  = 3'd4,
    S_DRAIN_IF = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam bit               c_timeout_en = (TIMEOUT != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stb;
  logic             r_we;
  logic [3:0]       r_sel;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_mem_data;
  logic [31:0]      r_if_inst;
  logic             r_timeout;
  logic             r_flushed;
  logic             r_dropped;

  logic             w_in_bus;
  logic             w_expire;
  logic             w_finish;
  logic [31:0]      w_rdata;
  logic             w_mem_drop;
  logic             w_if_flush;
  logic             w_if_drop;

  assign w_in_bus   = (r_state == S_BUS_MEM) || (r_state == S_BUS_IF);
  assign w_expire   = c_timeout_en && (r_cnt == c_timeout) && !bus.bus_ack_i;
  assign w_finish   = w_in_bus && (bus.bus_ack_i || w_expire);
  assign w_rdata    = w_expire ? 32'h0 : bus.bus_data_i;
  // Withdrawal or flush anywhere in the bus cycle, including its last cycle, discards the result.
  assign w_mem_drop = r_dropped | ~mem_ce_i;
  assign w_if_flush = r_flushed | flush_i;
  assign w_if_drop  = r_dropped | ~if_ce_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= 4'h0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_mem_data <= 32'h0;
      r_if_inst  <= 32'h0;
      r_timeout  <= 1'b0;
      r_flushed  <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_flushed <= 1'b0;
          r_dropped <= 1'b0;
          if (mem_ce_i) begin
            r_state <= S_BUS_MEM;
            r_stb   <= 1'b1;
            r_we    <= mem_we_i;
            r_sel   <= mem_sel_i;
            r_addr  <= mem_addr_i;
            r_wdata <= mem_data_i;
          end else if (if_ce_i) begin
            r_state <= S_BUS_IF;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_sel   <= 4'hF;
            r_addr  <= if_addr_i;
          end
        end
        S_BUS_MEM, S_BUS_IF: begin
          if (w_finish) begin
            r_stb     <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= w_expire;
            r_flushed <= 1'b0;
            r_dropped <= 1'b0;
            if (r_state == S_BUS_MEM) begin
              if (w_mem_drop) begin
                r_state <= S_IDLE;
              end else begin
                r_state <= S_DONE_MEM;
                if (!r_we) r_mem_data <= w_rdata;
              end
            end else if (w_if_flush) begin
              r_state <= S_DRAIN_IF;
            end else if (w_if_drop) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DONE_IF;
              r_if_inst <= w_rdata;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
            if ((r_state == S_BUS_IF) && flush_i) r_flushed <= 1'b1;
            if (((r_state == S_BUS_MEM) && !mem_ce_i) || ((r_state == S_BUS_IF) && !if_ce_i))
              r_dropped <= 1'b1;
          end
        end
        S_DONE_MEM, S_DONE_IF, S_DRAIN_IF: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_stb_o     = r_stb;
  assign bus.bus_we_o      = r_we;
  assign bus.bus_sel_o     = r_sel;
  assign bus.bus_addr_o    = r_addr;
  assign bus.bus_data_o    = r_wdata;
  assign bus.bus_timeout_o = r_timeout;
  assign mem_data_o        = r_mem_data;
  assign if_inst_o         = r_if_inst;

  // Gated by reset so both stalls read 0 while reset is asserted, even with requests pending.
  assign stallreq_mem_o = reset_n & mem_ce_i & (r_state != S_DONE_MEM);
  assign stallreq_if_o  = reset_n & if_ce_i  & (r_state != S_DONE_IF);

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed vector table plus hand-written timeout/flush/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        stallreq_if_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stallreq_mem_o;
  logic        flush_i;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .if_ce_i        (if_ce_i),
    .if_addr_i      (if_addr_i),
    .if_inst_o      (if_inst_o),
    .stallreq_if_o  (stallreq_if_o),
    .mem_ce_i       (mem_ce_i),
    .mem_we_i       (mem_we_i),
    .mem_sel_i      (mem_sel_i),
    .mem_addr_i     (mem_addr_i),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o),
    .stallreq_mem_o (stallreq_mem_o),
    .flush_i        (flush_i),
    .bus            (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          if_ce, mem_ce, we;
    bit [3:0]    sel;
    bit [31:0]   maddr, rdata;
    bit          ack, flush;
    bit          e_stb, e_we;
    bit [3:0]    e_sel;
    bit [31:0]   e_addr, e_wdata;
    bit          e_smem, e_sif, e_tmo;
    bit [31:0]   e_mdata, e_inst;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input bit ifc, input bit mc, input bit we,
                     input bit [3:0] sel, input bit [31:0] ma, input bit [31:0] rd,
                     input bit ack, input bit fl, input bit es, input bit ew,
                     input bit [3:0] esel, input bit [31:0] ea, input bit [31:0] ewd,
                     input bit esm, input bit esi, input bit et,
                     input bit [31:0] emd, input bit [31:0] ein);
    vec_t v;
    v.nm = nm; v.if_ce = ifc; v.mem_ce = mc; v.we = we; v.sel = sel; v.maddr = ma;
    v.rdata = rd; v.ack = ack; v.flush = fl; v.e_stb = es; v.e_we = ew; v.e_sel = esel;
    v.e_addr = ea; v.e_wdata = ewd; v.e_smem = esm; v.e_sif = esi; v.e_tmo = et;
    v.e_mdata = emd; v.e_inst = ein;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stb_n;
    int tmo_n;
    bit seen;

    reset_n = 1'b0;
    if_ce_i = 1'b1; if_addr_i = 32'h400;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h0;
    mem_data_i = 32'h12345678; flush_i = 1'b0;
    bus_if.bus_ack_i = 1'b0; bus_if.bus_data_i = 32'h0;

    // Reset state, with both requests pending to confirm the stalls stay low
    repeat (2) @(posedge clk);
    #2;
    chk("rst.stb",      32'(bus_if.bus_stb_o), 32'h0);
    chk("rst.addr",     bus_if.bus_addr_o, 32'h0);
    chk("rst.tmo",      32'(bus_if.bus_timeout_o), 32'h0);
    chk("rst.stallmem", 32'(stallreq_mem_o), 32'h0);
    chk("rst.stallif",  32'(stallreq_if_o), 32'h0);
    chk("rst.mdata",    mem_data_o, 32'h0);
    if_ce_i = 1'b0; mem_ce_i = 1'b0;
    #1 reset_n = 1'b1;

    //   nm     ifc mc we sel   maddr     rdata         ack fl | stb we sel   addr      wdata         smem sif tmo mdata         inst
    add("c0",  0,1,0,4'hF,32'h100,32'h0,        0,0,  0,0,4'h0,32'h0,  32'h0,        1,0,0,32'h0,        32'h0);
    add("c1",  0,1,0,4'hF,32'h100,32'h0,        0,0,  1,0,4'hF,32'h100,32'h12345678, 1,0,0,32'h0,        32'h0);
    add("c2",  0,1,0,4'hF,32'h100,32'hDEADBEEF, 1,1,  1,0,4'hF,32'h100,32'h12345678, 1,0,0,32'h0,        32'h0);
    add("c3",  0,1,0,4'hF,32'h100,32'h0,        0,0,  0,0,4'hF,32'h100,32'h12345678, 0,0,0,32'hDEADBEEF, 32'h0);
    add("c4",  0,0,0,4'hF,32'h100,32'h11111111, 1,0,  0,0,4'hF,32'h100,32'h12345678, 0,0,0,32'hDEADBEEF, 32'h0);
    add("c5",  1,1,0,4'hF,32'h200,32'h0,        0,0,  0,0,4'hF,32'h100,32'h12345678, 1,1,0,32'hDEADBEEF, 32'h0);
    add("c6",  1,1,0,4'hF,32'h200,32'hCAFE0001, 1,0,  1,0,4'hF,32'h200,32'h12345678, 1,1,0,32'hDEADBEEF, 32'h0);
    add("c7",  1,1,0,4'hF,32'h200,32'h0,        0,0,  0,0,4'hF,32'h200,32'h12345678, 0,1,0,32'hCAFE0001, 32'h0);
    add("c8",  1,0,0,4'hF,32'h200,32'h0,        0,0,  0,0,4'hF,32'h200,32'h12345678, 0,1,0,32'hCAFE0001, 32'h0);
    add("c9",  1,0,0,4'hF,32'h200,32'h0BADC0DE, 1,0,  1,0,4'hF,32'h400,32'h12345678, 0,1,0,32'hCAFE0001, 32'h0);
    add("c10", 1,0,0,4'hF,32'h200,32'h0,        0,0,  0,0,4'hF,32'h400,32'h12345678, 0,0,0,32'hCAFE0001, 32'h0BADC0DE);
    add("c11", 0,0,0,4'hF,32'h200,32'h0,        0,0,  0,0,4'hF,32'h400,32'h12345678, 0,0,0,32'hCAFE0001, 32'h0BADC0DE);
    add("c12", 0,1,1,4'h3,32'h300,32'h0,        0,0,  0,0,4'hF,32'h400,32'h12345678, 1,0,0,32'hCAFE0001, 32'h0BADC0DE);
    add("c13", 0,1,1,4'h3,32'h300,32'hFFFFFFFF, 1,0,  1,1,4'h3,32'h300,32'h12345678, 1,0,0,32'hCAFE0001, 32'h0BADC0DE);
    add("c14", 0,1,1,4'h3,32'h300,32'h0,        0,0,  0,1,4'h3,32'h300,32'h12345678, 0,0,0,32'hCAFE0001, 32'h0BADC0DE);
    add("c15", 0,0,0,4'h3,32'h300,32'h0,        0,0,  0,1,4'h3,32'h300,32'h12345678, 0,0,0,32'hCAFE0001, 32'h0BADC0DE);

    foreach (vq[i]) begin
      tick();
      if_ce_i = vq[i].if_ce; mem_ce_i = vq[i].mem_ce; mem_we_i = vq[i].we;
      mem_sel_i = vq[i].sel; mem_addr_i = vq[i].maddr; flush_i = vq[i].flush;
      bus_if.bus_ack_i = vq[i].ack; bus_if.bus_data_i = vq[i].rdata;
      #1;
      chk({vq[i].nm, ".stb"},   32'(bus_if.bus_stb_o),     32'(vq[i].e_stb));
      chk({vq[i].nm, ".we"},    32'(bus_if.bus_we_o),      32'(vq[i].e_we));
      chk({vq[i].nm, ".sel"},   32'(bus_if.bus_sel_o),     32'(vq[i].e_sel));
      chk({vq[i].nm, ".addr"},  bus_if.bus_addr_o,         vq[i].e_addr);
      chk({vq[i].nm, ".wdata"}, bus_if.bus_data_o,         vq[i].e_wdata);
      chk({vq[i].nm, ".smem"},  32'(stallreq_mem_o),       32'(vq[i].e_smem));
      chk({vq[i].nm, ".sif"},   32'(stallreq_if_o),        32'(vq[i].e_sif));
      chk({vq[i].nm, ".tmo"},   32'(bus_if.bus_timeout_o), 32'(vq[i].e_tmo));
      chk({vq[i].nm, ".mdata"}, mem_data_o,                vq[i].e_mdata);
      chk({vq[i].nm, ".inst"},  if_inst_o,                 vq[i].e_inst);
    end
    flush_i = 1'b0; bus_if.bus_ack_i = 1'b0;

    // Timeout: load that is never acknowledged
    tick();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h500;
    stb_n = 0; tmo_n = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      #1;
      if (bus_if.bus_stb_o) stb_n++;
      if (bus_if.bus_timeout_o) begin
        seen = 1'b1;
        tmo_n++;
        chk("to.mdata",    mem_data_o, 32'h0);
        chk("to.stallmem", 32'(stallreq_mem_o), 32'h0);
        chk("to.stb",      32'(bus_if.bus_stb_o), 32'h0);
        mem_ce_i = 1'b0;
      end
    end
    chk("to.seen", 32'(seen), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      if (bus_if.bus_timeout_o) tmo_n++;
      if (bus_if.bus_stb_o) stb_n++;
    end
    chk("to.stbcycles", 32'(stb_n), 32'd5);
    chk("to.pulses",    32'(tmo_n), 32'd1);
    mem_ce_i = 1'b0;

    // Flush during an instruction fetch: result dropped, then refetched
    tick();
    if_ce_i = 1'b1; if_addr_i = 32'h600;
    tick();
    flush_i = 1'b1;
    #1;
    chk("fl.busif.stb",  32'(bus_if.bus_stb_o), 32'h1);
    chk("fl.busif.addr", bus_if.bus_addr_o, 32'h600);
    tick();
    flush_i = 1'b0; bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h99999999;
    tick();
    bus_if.bus_ack_i = 1'b0;
    #1;
    chk("fl.drain.stb",  32'(bus_if.bus_stb_o), 32'h0);
    chk("fl.drain.inst", if_inst_o, 32'h0BADC0DE);
    chk("fl.drain.sif",  32'(stallreq_if_o), 32'h1);
    tick();
    #1;
    chk("fl.idle.sif",  32'(stallreq_if_o), 32'h1);
    chk("fl.idle.inst", if_inst_o, 32'h0BADC0DE);
    tick();
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h77777777;
    #1;
    chk("fl.refetch.stb", 32'(bus_if.bus_stb_o), 32'h1);
    tick();
    bus_if.bus_ack_i = 1'b0;
    #1;
    chk("fl.done.sif",  32'(stallreq_if_o), 32'h0);
    chk("fl.done.inst", if_inst_o, 32'h77777777);
    tick();
    if_ce_i = 1'b0;

    // Asynchronous reset in the middle of a MEM access
    tick();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h700;
    tick();
    #1;
    chk("ra.busmem.stb", 32'(bus_if.bus_stb_o), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ra.stb",      32'(bus_if.bus_stb_o), 32'h0);
    chk("ra.addr",     bus_if.bus_addr_o, 32'h0);
    chk("ra.sel",      32'(bus_if.bus_sel_o), 32'h0);
    chk("ra.wdata",    bus_if.bus_data_o, 32'h0);
    chk("ra.mdata",    mem_data_o, 32'h0);
    chk("ra.inst",     if_inst_o, 32'h0);
    chk("ra.stallmem", 32'(stallreq_mem_o), 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    chk("ra.rel.stallmem", 32'(stallreq_mem_o), 32'h1);
    tick();
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h55AA55AA;
    #1;
    chk("ra.again.stb",  32'(bus_if.bus_stb_o), 32'h1);
    chk("ra.again.addr", bus_if.bus_addr_o, 32'h700);
    tick();
    bus_if.bus_ack_i = 1'b0;
    #1;
    chk("ra.done.mdata",    mem_data_o, 32'h55AA55AA);
    chk("ra.done.stallmem", 32'(stallreq_mem_o), 32'h0);
    tick();
    mem_ce_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
